// File: rtl/image_pkg.sv
// image_pkg: shared state encoding, alignment record and grayscale weights
package image_pkg;
  typedef enum logic [2:0] {S_IDLE, S_VBLANK, S_ACTIVE, S_HBL, S_DONE} state_e;
  typedef struct packed {
    logic vs;
    logic act;
    logic dn;
  } align_t;
  // gray = (ch0 + 2*ch1 + ch2) >> 2, weights expressed as left shifts
  localparam int GRAY_C0_SH = 0;
  localparam int GRAY_C1_SH = 1;
  localparam int GRAY_C2_SH = 0;
  localparam int GRAY_SHIFT = 2;
endpackage

// File: rtl/pix_gray.sv
// pix_gray: combinational grayscale conversion, pass-through when mode is 0 or CH<3
module pix_gray
  import image_pkg::*;
#(
  parameter int CH = 3,
  parameter int DW = 8
) (
  input  logic             mode_i,
  input  logic [CH*DW-1:0] pix_i,
  output logic [CH*DW-1:0] pix_o
);
  if (CH >= 3) begin : g_gray
    logic [DW+1:0] sum;
    logic [DW-1:0] gray;
    always_comb begin
      sum   = ({2'b0, pix_i[0 +: DW]} << GRAY_C0_SH)
            + ({2'b0, pix_i[DW +: DW]} << GRAY_C1_SH)
            + ({2'b0, pix_i[2*DW +: DW]} << GRAY_C2_SH);
      gray  = sum[GRAY_SHIFT +: DW];
      pix_o = mode_i ? {CH{gray}} : pix_i;
    end
  end else begin : g_pass
    assign pix_o = pix_i;
  end
endmodule

// File: rtl/image_stream_gen.sv
// image_stream_gen: frame timing FSM that fetches pixels from memory and streams
// them with VSYNC/HSYNC, all flags delayed two cycles to line up with the data.
module image_stream_gen
  import image_pkg::*;
#(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 2,
  parameter int CH     = 3,
  parameter int DW     = 8,
  parameter int HBLANK = 2,
  parameter int VBLANK = 3,
  parameter int ADDR_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              continuous,
  input  logic              mode,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [CH*DW-1:0]  mem_rdata,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic              pix_valid,
  output logic [CH*DW-1:0]  data,
  output logic              ctrl_done,
  output logic              busy
);
  localparam int CW = $clog2(VBLANK + IMG_W + HBLANK + 1);
  localparam int RW = $clog2(IMG_H + 1);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      row_q, row_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  align_t             s1_q, s1_d, s2_q;
  logic [CH*DW-1:0]   data_q, pix;
  pix_gray #(.CH(CH), .DW(DW)) u_gray (
    .mode_i(mode),
    .pix_i (mem_rdata),
    .pix_o (pix)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    row_d   = row_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_VBLANK;
      end
      S_VBLANK: if (cnt_q == CW'(VBLANK - 1)) begin
        state_d = S_ACTIVE;
        cnt_d   = '0;
        row_d   = '0;
        addr_d  = '0;
      end
      S_ACTIVE: begin
        addr_d = addr_q + 1'b1;
        if (cnt_q == CW'(IMG_W - 1)) begin
          state_d = S_HBL;
          cnt_d   = '0;
        end
      end
      S_HBL: if (cnt_q == CW'(HBLANK - 1)) begin
        state_d = (row_q == RW'(IMG_H - 1)) ? S_DONE : S_ACTIVE;
        cnt_d   = '0;
        row_d   = row_q + 1'b1;
      end
      S_DONE: begin
        state_d = continuous ? S_VBLANK : S_IDLE;
        cnt_d   = '0;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    s1_d = '{vs: state_q == S_VBLANK, act: state_q == S_ACTIVE, dn: state_q == S_DONE};
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      s1_q    <= s1_d;
      s2_q    <= s1_q;
      // s1_q.act marks the cycle the memory word for an ACTIVE read is present
      data_q  <= s1_q.act ? pix : data_q;
    end
  end
  assign mem_rd_en = state_q == S_ACTIVE;
  assign mem_addr  = addr_q;
  assign VSYNC     = s2_q.vs;
  assign HSYNC     = s2_q.act;
  assign pix_valid = s2_q.act;
  assign ctrl_done = s2_q.dn;
  assign data      = data_q;
  assign busy      = (state_q != S_IDLE) || (|s1_q) || (|s2_q);
endmodule

// File: tb/tb_image_stream_gen.sv
// tb_image_stream_gen: table-driven frame check plus directed gray, continuous,
// busy-start, mid-frame reset and 1x1 image sequences.
module tb_image_stream_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, start, cont, mode, start1;
  logic rd, vs, hs, pv, dn, bz;
  logic [2:0] addr;
  logic [23:0] rdata, data;
  logic rd1, vs1, hs1, pv1, dn1, bz1;
  logic [0:0] addr1;
  logic [23:0] rdata1, data1;
  logic [23:0] mem [8];
  int total = 0, bad = 0;

  image_stream_gen dut (
    .HCLK(clk), .HRESETn(rstn), .start(start), .continuous(cont), .mode(mode),
    .mem_rd_en(rd), .mem_addr(addr), .mem_rdata(rdata), .VSYNC(vs), .HSYNC(hs),
    .pix_valid(pv), .data(data), .ctrl_done(dn), .busy(bz)
  );
  image_stream_gen #(.IMG_W(1), .IMG_H(1), .HBLANK(1)) u1 (
    .HCLK(clk), .HRESETn(rstn), .start(start1), .continuous(1'b0), .mode(1'b0),
    .mem_rd_en(rd1), .mem_addr(addr1), .mem_rdata(rdata1), .VSYNC(vs1), .HSYNC(hs1),
    .pix_valid(pv1), .data(data1), .ctrl_done(dn1), .busy(bz1)
  );
  always @(posedge clk) rdata <= mem[addr];
  always @(posedge clk) rdata1 <= (addr1 == 1'b0) ? 24'hC0FFEE : 24'h0;

  typedef struct {
    logic md, rd;
    logic [2:0] ad;
    logic vs, hs, dn, bz;
    logic [23:0] d;
  } vec_t;
  vec_t tv [20];

  function automatic vec_t mk(logic r, logic [2:0] a, logic v, logic h, logic n, logic b, logic [23:0] d);
    return '{md: 1'b0, rd: r, ad: a, vs: v, hs: h, dn: n, bz: b, d: d};
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk_idle(string nm);
    chk({nm, "_ctl"}, {24'h0, rd, addr, vs, hs, pv, dn, bz}, 32'h0);
    chk({nm, "_data"}, {8'h0, data}, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string nm);
    int i;
    i = 0;
    @(negedge clk);
    while (bz && i < 64) begin
      step();
      @(negedge clk);
      i++;
    end
    chk({nm, "_drain"}, {31'h0, bz}, 32'h0);
    step();
  endtask

  initial begin
    int cnt, pcyc [3], dcyc;
    for (int i = 0; i < 8; i++) mem[i] = {3{8'(i)}};
    tv[0]  = mk(0, 0, 0, 0, 0, 0, 24'h0);
    tv[1]  = mk(0, 0, 0, 0, 0, 1, 24'h0);
    tv[2]  = mk(0, 0, 0, 0, 0, 1, 24'h0);
    tv[3]  = mk(0, 0, 1, 0, 0, 1, 24'h0);
    tv[4]  = mk(1, 0, 1, 0, 0, 1, 24'h0);
    tv[5]  = mk(1, 1, 1, 0, 0, 1, 24'h0);
    tv[6]  = mk(1, 2, 0, 1, 0, 1, 24'h000000);
    tv[7]  = mk(1, 3, 0, 1, 0, 1, 24'h010101);
    tv[8]  = mk(0, 4, 0, 1, 0, 1, 24'h020202);
    tv[9]  = mk(0, 4, 0, 1, 0, 1, 24'h030303);
    tv[10] = mk(1, 4, 0, 0, 0, 1, 24'h030303);
    tv[11] = mk(1, 5, 0, 0, 0, 1, 24'h030303);
    tv[12] = mk(1, 6, 0, 1, 0, 1, 24'h040404);
    tv[13] = mk(1, 7, 0, 1, 0, 1, 24'h050505);
    tv[14] = mk(0, 0, 0, 1, 0, 1, 24'h060606);
    tv[15] = mk(0, 0, 0, 1, 0, 1, 24'h070707);
    tv[16] = mk(0, 0, 0, 0, 0, 1, 24'h070707);
    tv[17] = mk(0, 0, 0, 0, 0, 1, 24'h070707);
    tv[18] = mk(0, 0, 0, 0, 1, 1, 24'h070707);
    tv[19] = mk(0, 0, 0, 0, 0, 0, 24'h070707);

    rstn = 0; start = 0; cont = 0; mode = 0; start1 = 0;
    repeat (2) step();
    @(negedge clk);
    chk_idle("reset");
    chk("reset_u1", {27'h0, rd1, vs1, hs1, dn1, bz1}, 32'h0);
    step();

    // start presented on the very first edge with reset released
    rstn = 1;
    for (int k = 0; k < 20; k++) begin
      start = (k == 0);
      mode = tv[k].md;
      @(negedge clk);
      chk($sformatf("frame_ctl[%0d]", k), {24'h0, rd, addr, vs, hs, pv, dn, bz},
          {24'h0, tv[k].rd, tv[k].ad, tv[k].vs, tv[k].hs, tv[k].hs, tv[k].dn, tv[k].bz});
      chk($sformatf("frame_data[%0d]", k), {8'h0, data}, {8'h0, tv[k].d});
      step();
    end

    mem[0] = 24'h302010; mem[1] = 24'hFFFFFF; mem[2] = 24'h000040; mem[3] = 24'h0100FF;
    for (int k = 0; k < 10; k++) begin
      start = (k == 0);
      mode = (k <= 6 || k >= 8);
      @(negedge clk);
      if (k == 6) chk("gray_mid", {8'h0, data}, 32'h202020);
      if (k == 7) chk("gray_max", {8'h0, data}, 32'hFFFFFF);
      if (k == 8) chk("gray_off", {8'h0, data}, 32'h000040);
      if (k == 9) chk("gray_back", {8'h0, data}, 32'h404040);
      step();
    end
    mode = 0;
    wait_idle("gray");
    for (int i = 0; i < 8; i++) mem[i] = {3{8'(i)}};

    cnt = 0; dcyc = -1;
    for (int k = 0; k < 40; k++) begin
      start = (k == 0 || k == 5 || k == 12 || k == 16);
      @(negedge clk);
      if (dn) begin cnt++; dcyc = k; end
      step();
    end
    start = 0;
    chk("busy_start_count", cnt, 1);
    chk("busy_start_cycle", dcyc, 18);
    wait_idle("busy_start");

    cnt = 0;
    for (int k = 0; k < 70; k++) begin
      start = (k == 0);
      cont = (k < 40);
      @(negedge clk);
      if (dn) begin
        if (cnt < 3) pcyc[cnt] = k;
        cnt++;
      end
      step();
    end
    chk("cont_count", cnt, 3);
    if (cnt >= 3) begin
      chk("cont_p0", pcyc[0], 18);
      chk("cont_p1", pcyc[1], 34);
      chk("cont_p2", pcyc[2], 50);
    end
    wait_idle("cont");

    for (int k = 0; k < 12; k++) begin
      start = (k == 0);
      @(negedge clk);
      if (k < 11) step();
    end
    start = 0;
    chk("mid_addr", {28'h0, rd, addr}, {28'h0, 1'b1, 3'd5});
    rstn = 0;
    step();
    @(negedge clk);
    chk_idle("mid_reset");
    step();
    rstn = 1;
    for (int k = 0; k < 8; k++) begin
      start = (k == 0);
      @(negedge clk);
      if (k == 4) chk("restart_addr", {28'h0, rd, addr}, {28'h0, 1'b1, 3'd0});
      if (k == 6) chk("restart_data", {7'h0, pv, data}, {7'h0, 1'b1, 24'h000000});
      step();
    end
    start = 0;
    wait_idle("restart");

    cnt = 0; dcyc = -1;
    for (int k = 0; k < 20; k++) begin
      start1 = (k == 0);
      @(negedge clk);
      if (pv1) begin
        cnt++;
        chk("one_data", {8'h0, data1}, 32'hC0FFEE);
      end
      if (dn1) dcyc = k;
      step();
    end
    start1 = 0;
    chk("one_pv_count", cnt, 1);
    chk("one_done_cycle", dcyc, 8);
    @(negedge clk);
    chk("one_idle", {31'h0, bz1}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/image_stream_gen.md
IMAGE_STREAM_GEN -- requirements
Module: image_stream_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- IMG_W, 4: active pixels per line, at least 1.
- IMG_H, 2: active lines per frame, at least 1.
- CH, 3: channels per pixel.
- DW, 8: bits per channel.
- HBLANK, 2: idle cycles after each line, at least 1.
- VBLANK, 3: VSYNC cycles before each frame, at least 1.
- ADDR_W, clog2(IMG_W*IMG_H): pixel address width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- HCLK, in, 1: the single clock.
- HRESETn, in, 1: reset, synchronous, active-low.
- start, in, 1: one-cycle frame request.
- continuous, in, 1: 1 = restart frames back-to-back.
- mode, in, 1: 0 = pass-through, 1 = grayscale.
- mem_rd_en, out, 1: pixel read strobe.
- mem_addr, out, ADDR_W: pixel address.
- mem_rdata, in, CH*DW: pixel word, valid the cycle after mem_rd_en.
- VSYNC, out, 1: frame sync.
- HSYNC, out, 1: line-active flag.
- pix_valid, out, 1: pix_data is valid.
- data, out, CH*DW: pixel output.
- ctrl_done, out, 1: one-cycle end-of-frame pulse.
- busy, out, 1: frame in progress.

Function
REQ-003 States: IDLE, VBLANK, ACTIVE, HBL, DONE.
REQ-004 IDLE: start=1 -> VBLANK. start is ignored in every other state.
REQ-005 VBLANK: stays exactly VBLANK cycles, then -> ACTIVE with row=0, col=0, mem_addr=0.
REQ-006 ACTIVE: mem_rd_en=1 each cycle; mem_addr increments by 1 per cycle (counter, no multiplier); after IMG_W cycles -> HBL.
REQ-007 HBL: stays exactly HBLANK cycles; then -> ACTIVE if row<IMG_H-1 (row+1), else -> DONE.
REQ-008 DONE: lasts 1 cycle; -> VBLANK if continuous=1 (sampled in DONE), else -> IDLE; mem_addr resets to 0.
REQ-009 Internal frame length from start to DONE inclusive: VBLANK + IMG_H*(IMG_W+HBLANK) + 1 cycles.
REQ-010 Output timeline: VSYNC, HSYNC, pix_valid and ctrl_done are derived from state and delayed 2 cycles, aligned with data. data is registered from mem_rdata one cycle after it arrives.
- VSYNC = delayed (state==VBLANK).
- HSYNC = pix_valid = delayed (state==ACTIVE).
- ctrl_done = delayed (state==DONE).
REQ-011 busy = (state != IDLE) OR any alignment stage nonzero.
REQ-012 mode=0: data = mem_rdata unchanged.
REQ-013 mode=1 with CH>=3: gray = (ch0 + 2*ch1 + ch2) >> 2, computed at DW+2 bits and truncated to DW; every channel of data = gray. With CH<3, mode is ignored and data passes through.
REQ-014 mode is sampled per pixel. A change mid-frame takes effect on the next pixel.
REQ-015 When pix_valid=0, data holds its last value.
REQ-016 A continuous change mid-frame has effect only at DONE.

Reset
REQ-017 HRESETn=0 at a clock edge forces on that edge, including mid-frame:
- state IDLE; all counters 0; alignment pipeline cleared.
- mem_rd_en, mem_addr, VSYNC, HSYNC, pix_valid, data, ctrl_done, busy all 0.
REQ-018 The first start is accepted on the first edge after HRESETn returns to 1.

Structure
REQ-019 State encoding and the grayscale coefficient/shift constants are in the shared package image_pkg.
REQ-020 Timing FSM and counters live in image_stream_gen. Grayscale arithmetic is a single combinational sub-module, pix_gray.

Verification (defaults, CH=3, DW=8; memory model returns {addr,addr,addr})
REQ-021 Single frame: start at cycle 0 ->
- VSYNC high 3 cycles.
- Two HSYNC bursts of 4 cycles each, 2 idle cycles between bursts.
- data channels = 0,1,2,3 then 4,5,6,7.
- ctrl_done pulses once, 18 cycles after start.
- busy=0 afterwards.
REQ-022 Grayscale: mode=1 with mem_rdata ch0=0x10, ch1=0x20, ch2=0x30 -> every channel of data = 0x20. ch0=ch1=ch2=0xFF -> 0xFF.
REQ-023 Continuous: continuous=1 -> VBLANK follows DONE directly; frame period 16 cycles; 3 consecutive ctrl_done pulses 16 cycles apart.
REQ-024 start asserted while busy=1 -> ignored; exactly one ctrl_done per accepted start.
REQ-025 HRESETn=0 at an ACTIVE cycle with mem_addr=5 -> all outputs 0 on the next edge; a new start then restarts from mem_addr=0.
REQ-026 IMG_W=1, IMG_H=1 -> exactly one pix_valid pulse with data = pixel at address 0; ctrl_done pulses 8 cycles after start.
